// File: rtl/led_pattern_gen.sv
// led_pattern_gen: latches LED slave command pulses and drives timed LED patterns (static, blink, run, bounce, alt, breathing PWM).
// Define LED_ACTIVE_LOW_EN to drive the led port inverted (active-low board LEDs).
module led_pattern_gen #(
  parameter int LED_W      = 8,
  parameter int TICK_DIV   = 25000000,
  parameter int BREATH_DIV = 50000,
  parameter int PWM_BITS   = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [2:0]       mode,
  output logic [LED_W-1:0] led,
  output logic [2:0]       cur_mode
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BREATH_LAST = BW'(BREATH_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [LED_W-1:0] ALT = LED_W'({LED_W{2'b01}});
  typedef enum logic [2:0] {M_NONE, M_ON, M_BLINK, M_RUN, M_BOUNCE, M_ALT, M_BREATH, M_OFF} mode_t;
  mode_t               r_cur_mode;
  logic [LED_W-1:0]    r_pat;
  logic [TW-1:0]       r_tick;
  logic [BW-1:0]       r_bcnt;
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_up;
  logic                w_tick_last;
  logic                w_b_last;
  logic                w_bounce_up;
  logic                w_duty_up;
  logic [LED_W-1:0]    w_init;
  logic [LED_W-1:0]    w_step;
  always_comb begin
    w_tick_last = r_tick == TICK_LAST;
    w_b_last = r_bcnt == BREATH_LAST;
    w_init = (mode == M_ON || mode == M_BLINK) ? '1 :
             (mode == M_RUN || mode == M_BOUNCE) ? LED_W'(1) :
             (mode == M_ALT) ? ALT : '0;
    // Bounce turns around on the step that leaves an end bit, so ends are never held
    w_bounce_up = r_up ? !r_pat[LED_W-1] : r_pat[0];
    w_duty_up = r_up ? (r_duty != DUTY_MAX) : (r_duty == '0);
    w_step = (r_cur_mode == M_ON) ? '1 :
             (r_cur_mode == M_BLINK || r_cur_mode == M_ALT) ? ~r_pat :
             (r_cur_mode == M_RUN) ? {r_pat[LED_W-2:0], r_pat[LED_W-1]} :
             (r_cur_mode == M_BOUNCE) ? (w_bounce_up ? r_pat << 1 : r_pat >> 1) : '0;
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cur_mode <= M_OFF;
      r_pat <= '0;
      r_tick <= '0;
      r_bcnt <= '0;
      r_pwm <= '0;
      r_duty <= '0;
      r_up <= 1'b1;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      r_tick <= w_tick_last ? '0 : r_tick + 1'b1;
      r_bcnt <= w_b_last ? '0 : r_bcnt + 1'b1;
      if (mode != 3'd0) begin
        r_cur_mode <= mode_t'(mode);
        r_pat <= w_init;
        r_tick <= '0;
        r_bcnt <= '0;
        r_pwm <= '0;
        r_duty <= '0;
        r_up <= 1'b1;
      end else if (r_cur_mode == M_BREATH) begin
        r_pat <= (r_pwm < r_duty) ? '1 : '0;
        if (w_b_last) begin
          r_duty <= w_duty_up ? r_duty + 1'b1 : r_duty - 1'b1;
          r_up <= w_duty_up;
        end
      end else if (w_tick_last) begin
        r_pat <= w_step;
        if (r_cur_mode == M_BOUNCE) r_up <= w_bounce_up;
      end
    end
  end
`ifdef LED_ACTIVE_LOW_EN
  assign led = ~r_pat;
`else
  assign led = r_pat;
`endif
  assign cur_mode = r_cur_mode;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench; stimulus queues expected led/cur_mode per cycle, a monitor compares after each edge.
module tb_led_pattern_gen;
  logic       HCLK;
  logic       HRESET;
  logic [2:0] mode;
  logic [7:0] led;
  logic [2:0] cur_mode;
  typedef struct {logic [7:0] led; logic [2:0] cm; int id;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_id = 0;
  logic [7:0] bounce_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
  int duty_tab [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
  led_pattern_gen #(.LED_W(8), .TICK_DIV(4), .BREATH_DIV(2), .PWM_BITS(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .mode(mode), .led(led), .cur_mode(cur_mode)
  );
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction
  task automatic step(input logic [2:0] m, input logic [7:0] e_led, input logic [2:0] e_cm);
    exp_t e;
    @(negedge HCLK);
    mode = m;
    e.led = pol(e_led);
    e.cm = e_cm;
    e.id = n_id++;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (led !== e.led || cur_mode !== e.cm) begin
          n_bad++;
          $display("FAIL cycle_check #%0d: led=%h cur_mode=%0d, required led=%h cur_mode=%0d",
                   e.id, led, cur_mode, e.led, e.cm);
        end
      end
    end
  end
  initial begin
    HRESET = 1'b1;
    mode = 3'd0;
    #2;
    n_cmp++;
    if (led !== pol(8'h00) || cur_mode !== 3'd7) begin
      n_bad++;
      $display("FAIL reset_state: led=%h cur_mode=%0d, required led=%h cur_mode=7", led, cur_mode, pol(8'h00));
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    for (int c = 0; c < 20; c++) step(3'd0, 8'h00, 3'd7);
    step(3'd3, 8'h01, 3'd3);
    for (int c = 1; c < 36; c++) step(3'd0, 8'h01 << ((c / 4) % 8), 3'd3);
    step(3'd4, 8'h01, 3'd4);
    for (int c = 1; c <= 64; c++) step(3'd0, bounce_tab[(c / 4) % 14], 3'd4);
    step(3'd2, 8'hFF, 3'd2);
    for (int c = 1; c < 4; c++) step(3'd0, 8'hFF, 3'd2);
    step(3'd5, 8'h55, 3'd5);
    for (int c = 1; c < 4; c++) step(3'd0, 8'h55, 3'd5);
    for (int c = 4; c < 8; c++) step(3'd0, 8'hAA, 3'd5);
    step(3'd0, 8'h55, 3'd5);
    step(3'd1, 8'hFF, 3'd1);
    for (int c = 1; c < 6; c++) step(3'd0, 8'hFF, 3'd1);
    step(3'd6, 8'h00, 3'd6);
    for (int c = 1; c <= 60; c++)
      step(3'd0, (((c - 1) % 8) < duty_tab[((c - 1) / 2) % 14]) ? 8'hFF : 8'h00, 3'd6);
    step(3'd7, 8'h00, 3'd7);
    step(3'd0, 8'h00, 3'd7);
    step(3'd2, 8'hFF, 3'd2);
    for (int c = 1; c < 4; c++) step(3'd0, 8'hFF, 3'd2);
    step(3'd0, 8'h00, 3'd2);
    step(3'd0, 8'h00, 3'd2);
    @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    n_cmp++;
    if (led !== pol(8'h00) || cur_mode !== 3'd7) begin
      n_bad++;
      $display("FAIL async_reset: led=%h cur_mode=%0d, required led=%h cur_mode=7", led, cur_mode, pol(8'h00));
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
